// File: rtl/croc_pkg.sv
// Shared croc SoC types: address-map rule and the subordinate-side OBI request/response.
package croc_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned AidWidth  = 2;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
    logic [AidWidth-1:0]    aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    sbr_obi_a_chan_t a;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic [AidWidth-1:0]  rid;
    logic                 err;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

endpackage

// File: rtl/user_pkg.sv
// User-domain address map: subordinate indices, base/range constants and the default rule table.
package user_pkg;
  import croc_pkg::*;

  localparam int unsigned NumUserDomainSubordinates = 2;

  typedef enum logic [1:0] {
    UserError = 2'd0,
    UserRom   = 2'd1,
    UserFlash = 2'd2
  } user_demux_outputs_e;

  localparam logic [31:0] UserRomAddrOffset   = 32'h2000_0000;
  localparam logic [31:0] UserRomAddrRange    = 32'h0000_1000;
  localparam logic [31:0] UserFlashAddrOffset = 32'h2000_5000;
  localparam logic [31:0] UserFlashAddrRange  = 32'h0100_0000;

  localparam logic [31:0] UserErrRdata = 32'hBADC_AB1E;

  localparam addr_map_rule_t [NumUserDomainSubordinates-1:0] user_addr_map = '{
    0: '{idx: 32'(UserRom),   start_addr: UserRomAddrOffset,
         end_addr: UserRomAddrOffset + UserRomAddrRange},
    1: '{idx: 32'(UserFlash), start_addr: UserFlashAddrOffset,
         end_addr: UserFlashAddrOffset + UserFlashAddrRange}
  };

endpackage

// File: rtl/user_demux_err_sbr.sv
// Error subordinate for unmapped addresses: grants on request, answers one cycle later with err=1.
// With USER_DEMUX_ERR_LOG_EN it also keeps a sticky record of the first faulting address.
module user_demux_err_sbr
  import croc_pkg::*;
  import user_pkg::*;
#(
  parameter int unsigned AidW    = croc_pkg::AidWidth,
  parameter type         ObiRspT = sbr_obi_rsp_t
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic [AidW-1:0] aid_i,
  output ObiRspT          rsp_o
`ifdef USER_DEMUX_ERR_LOG_EN
  ,
  input  logic [31:0]     addr_i,
  input  logic            err_clear_i,
  output logic            err_valid_o,
  output logic [31:0]     err_addr_o
`endif
);

  ObiRspT rsp_q;

  // Response register is rebuilt every cycle so r fields read as zero between responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= '0;
      if (req_i) begin
        rsp_q.rvalid  <= 1'b1;
        rsp_q.r.rdata <= UserErrRdata;
        rsp_q.r.rid   <= aid_i;
        rsp_q.r.err   <= 1'b1;
      end
    end
  end

  always_comb begin
    rsp_o     = rsp_q;
    rsp_o.gnt = req_i;
  end

`ifdef USER_DEMUX_ERR_LOG_EN
  logic        log_valid;
  logic [31:0] log_addr;

  // A clear coinciding with a new error still captures the new one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      log_valid <= 1'b0;
      log_addr  <= '0;
    end else if (req_i && (!log_valid || err_clear_i)) begin
      log_valid <= 1'b1;
      log_addr  <= addr_i;
    end else if (err_clear_i) begin
      log_valid <= 1'b0;
    end
  end

  assign err_valid_o = log_valid;
  assign err_addr_o  = log_addr;
`endif

endmodule

// File: rtl/user_obi_demux.sv
// OBI demux for the user domain: rule-table decode, in-order outstanding tracking, error port at idx 0.
// Optional sticky error-address log is enabled with USER_DEMUX_ERR_LOG_EN.
module user_obi_demux
  import croc_pkg::*;
  import user_pkg::*;
#(
  parameter int unsigned                    NumRules = NumUserDomainSubordinates,
  parameter int unsigned                    MaxTrans = 4,
  parameter addr_map_rule_t [NumRules-1:0] AddrMap  = user_addr_map,
  parameter type                            ObiReqT  = sbr_obi_req_t,
  parameter type                            ObiRspT  = sbr_obi_rsp_t
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  ObiReqT                sbr_req_i,
  output ObiRspT                sbr_rsp_o,
  output ObiReqT [NumRules-1:0] mgr_req_o,
  input  ObiRspT [NumRules-1:0] mgr_rsp_i
`ifdef USER_DEMUX_ERR_LOG_EN
  ,
  output logic                  err_valid_o,
  output logic [31:0]           err_addr_o,
  input  logic                  err_clear_i
`endif
);

  localparam int unsigned IdxW = $clog2(NumRules + 1);
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  logic [IdxW-1:0] sel_idx, cur_idx;
  logic [CntW-1:0] cnt;
  logic            matched, allow, hs, rv, sel_gnt, cur_rvalid, err_req;
  ObiRspT          err_rsp;

  // Lowest matching rule wins; no match falls through to the error port (idx 0).
  always_comb begin
    sel_idx = '0;
    matched = 1'b0;
    for (int i = 0; i < NumRules; i++) begin
      if (!matched && sbr_req_i.a.addr >= AddrMap[i].start_addr &&
          sbr_req_i.a.addr < AddrMap[i].end_addr) begin
        sel_idx = IdxW'(AddrMap[i].idx);
        matched = 1'b1;
      end
    end
  end

  assign allow = (cnt == '0) || (sel_idx == cur_idx && cnt < CntW'(MaxTrans));

  always_comb begin
    for (int i = 0; i < NumRules; i++) begin
      mgr_req_o[i]     = sbr_req_i;
      mgr_req_o[i].req = sbr_req_i.req && allow && (sel_idx == IdxW'(i + 1));
    end
  end

  assign err_req = sbr_req_i.req && allow && (sel_idx == '0);

  always_comb begin
    sel_gnt    = err_rsp.gnt;
    cur_rvalid = err_rsp.rvalid;
    sbr_rsp_o  = '0;
    sbr_rsp_o.r = err_rsp.r;
    for (int i = 0; i < NumRules; i++) begin
      if (sel_idx == IdxW'(i + 1)) sel_gnt = mgr_rsp_i[i].gnt;
      if (cur_idx == IdxW'(i + 1)) begin
        cur_rvalid  = mgr_rsp_i[i].rvalid;
        sbr_rsp_o.r = mgr_rsp_i[i].r;
      end
    end
    // Nothing outstanding means any rvalid is stale (e.g. left over from before a reset).
    sbr_rsp_o.rvalid = cur_rvalid && (cnt != '0);
    sbr_rsp_o.gnt    = sel_gnt && allow;
  end

  assign rv = sbr_rsp_o.rvalid;
  assign hs = sbr_req_i.req && sbr_rsp_o.gnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt     <= '0;
      cur_idx <= '0;
    end else begin
      if (hs) cur_idx <= sel_idx;
      case ({hs, rv})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  user_demux_err_sbr #(
    .AidW    (AidWidth),
    .ObiRspT (ObiRspT)
  ) i_err_sbr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (err_req),
    .aid_i       (sbr_req_i.a.aid),
    .rsp_o       (err_rsp)
`ifdef USER_DEMUX_ERR_LOG_EN
    ,
    .addr_i      (sbr_req_i.a.addr),
    .err_clear_i (err_clear_i),
    .err_valid_o (err_valid_o),
    .err_addr_o  (err_addr_o)
`endif
  );

endmodule

// File: tb/tb_user_obi_demux.sv
// Bench for user_obi_demux: directed scenarios then random traffic against a queue-based reference.
module tb_user_obi_demux;
  import croc_pkg::*;

  localparam int MaxTrans = 4;

  logic               clk = 1'b0;
  logic               rst;
  sbr_obi_req_t       sbr_req;
  sbr_obi_rsp_t       sbr_rsp;
  sbr_obi_req_t [1:0] mgr_req;
  sbr_obi_rsp_t [1:0] mgr_rsp;
`ifdef USER_DEMUX_ERR_LOG_EN
  logic               err_valid;
  logic [31:0]        err_addr;
  logic               err_clear;
`endif

  int vectors = 0, miscompares = 0;

  // Reference: queue of targets of outstanding transactions, oldest first.
  int          tq[$];
  bit          err_due;
  logic [1:0]  err_rid;
  bit          lv;
  logic [31:0] la;
  bit          m_hs, m_rv;
  int          m_sel;

  always #5 clk = ~clk;

  user_obi_demux dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .sbr_req_i (sbr_req),
    .sbr_rsp_o (sbr_rsp),
    .mgr_req_o (mgr_req),
    .mgr_rsp_i (mgr_rsp)
`ifdef USER_DEMUX_ERR_LOG_EN
    ,
    .err_valid_o (err_valid),
    .err_addr_o  (err_addr),
    .err_clear_i (err_clear)
`endif
  );

  function automatic int decode(input logic [31:0] a);
    if (a >= 32'h2000_0000 && a < 32'h2000_1000) return 1;
    if (a >= 32'h2000_5000 && a < 32'h2100_5000) return 2;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int sel, t;
    bit allow, sg, erv;
    sel   = decode(sbr_req.a.addr);
    allow = (tq.size() == 0) || (tq[0] == sel && tq.size() < MaxTrans);
    sg    = (sel == 0) ? sbr_req.req : mgr_rsp[sel-1].gnt;
    chk("gnt", 32'(allow && sg), 32'(sbr_rsp.gnt));
    for (int i = 0; i < 2; i++)
      chk($sformatf("mgr_req%0d", i), 32'(mgr_req[i].req), 32'(sbr_req.req && allow && sel == i + 1));
    chk("addr_pass", mgr_req[1].a.addr, sbr_req.a.addr);
    t   = (tq.size() > 0) ? tq[0] : -1;
    erv = (t == 0) ? err_due : (t > 0) ? mgr_rsp[t-1].rvalid : 1'b0;
    chk("rvalid", 32'(sbr_rsp.rvalid), 32'(erv));
    if (erv && t == 0) begin
      chk("err_rdata", sbr_rsp.r.rdata, 32'hBADC_AB1E);
      chk("err_err", 32'(sbr_rsp.r.err), 32'd1);
      chk("err_rid", 32'(sbr_rsp.r.rid), 32'(err_rid));
    end else if (erv) begin
      chk("rdata", sbr_rsp.r.rdata, mgr_rsp[t-1].r.rdata);
      chk("err", 32'(sbr_rsp.r.err), 32'(mgr_rsp[t-1].r.err));
      chk("rid", 32'(sbr_rsp.r.rid), 32'(mgr_rsp[t-1].r.rid));
    end
`ifdef USER_DEMUX_ERR_LOG_EN
    chk("err_valid", 32'(err_valid), 32'(lv));
    if (lv) chk("err_addr", err_addr, la);
`endif
    m_sel = sel;
    m_hs  = sbr_req.req && allow && sg;
    m_rv  = erv;
  endtask

  task automatic model_clear();
    tq.delete();
    err_due = 1'b0;
    lv      = 1'b0;
    la      = '0;
  endtask

  // One clock: check outputs mid-cycle, advance the reference at the edge.
  task automatic tick();
    #2 check_outputs();
    @(posedge clk);
    if (rst) model_clear();
    else begin
      if (m_rv) void'(tq.pop_front());
      if (m_hs) tq.push_back(m_sel);
`ifdef USER_DEMUX_ERR_LOG_EN
      if (m_hs && m_sel == 0 && (!lv || err_clear)) begin
        lv = 1'b1;
        la = sbr_req.a.addr;
      end else if (err_clear) lv = 1'b0;
`endif
      err_due = m_hs && m_sel == 0;
      err_rid = sbr_req.a.aid;
    end
    #1;
  endtask

  task automatic idle();
    sbr_req = '0;
    mgr_rsp = '0;
`ifdef USER_DEMUX_ERR_LOG_EN
    err_clear = 1'b0;
`endif
  endtask

  task automatic set_req(input logic [31:0] a, input logic [1:0] aid);
    sbr_req.req    = 1'b1;
    sbr_req.a.addr = a;
    sbr_req.a.aid  = aid;
    sbr_req.a.we   = 1'b0;
  endtask

  logic [31:0] addrs [10] = '{32'h2000_0000, 32'h2000_0010, 32'h2000_0FFC, 32'h2000_1000,
                              32'h2000_4FFC, 32'h2000_5000, 32'h2010_0000, 32'h2100_4FFC,
                              32'h2100_5000, 32'h1FFF_FFFC};

  initial begin
    model_clear();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
`ifdef USER_DEMUX_ERR_LOG_EN
    chk("log_rst_valid", 32'(err_valid), 32'd0);
    chk("log_rst_addr", err_addr, 32'd0);
`endif
    tick();

    // ROM read, response two cycles after the grant
    set_req(32'h2000_0010, 2'd1);
    mgr_rsp[0].gnt = 1'b1;
    tick();
    sbr_req.req = 1'b0;
    tick();
    mgr_rsp[0].rvalid  = 1'b1;
    mgr_rsp[0].r.rdata = 32'h1234_5678;
    mgr_rsp[0].r.rid   = 2'd1;
    tick();
    idle();
    tick();

    // Unmapped read answered by the error port
    set_req(32'h2000_4000, 2'd2);
    tick();
    idle();
    tick();
    tick();

    // Flash saturation at MaxTrans, release one cycle after the first rvalid
    mgr_rsp[1].gnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_req(32'h2000_5000, 2'(i));
      tick();
    end
    mgr_rsp[1].rvalid  = 1'b1;
    mgr_rsp[1].r.rdata = 32'hF1A5_0000;
    tick();
    mgr_rsp[1].rvalid = 1'b0;
    tick();
    sbr_req.req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mgr_rsp[1].rvalid  = 1'b1;
      mgr_rsp[1].r.rdata = 32'hF1A5_0001 + 32'(i);
      tick();
    end
    idle();
    tick();

    // Target switch stalls until the ROM response
    set_req(32'h2000_0100, 2'd3);
    mgr_rsp[0].gnt = 1'b1;
    tick();
    set_req(32'h2000_5000, 2'd0);
    mgr_rsp[1].gnt = 1'b1;
    tick();
    tick();
    mgr_rsp[0].rvalid  = 1'b1;
    mgr_rsp[0].r.rdata = 32'hAAAA_0001;
    tick();
    mgr_rsp[0].rvalid = 1'b0;
    tick();
    sbr_req.req        = 1'b0;
    mgr_rsp[1].rvalid  = 1'b1;
    mgr_rsp[1].r.rdata = 32'hBBBB_0002;
    tick();
    idle();
    tick();

    // Reset with two ROM reads outstanding; a late ROM rvalid must be dropped
    set_req(32'h2000_0020, 2'd1);
    mgr_rsp[0].gnt = 1'b1;
    tick();
    tick();
    idle();
    rst = 1'b1;
    model_clear();
    tick();
    rst = 1'b0;
    mgr_rsp[0].rvalid  = 1'b1;
    mgr_rsp[0].r.rdata = 32'hDEAD_0000;
    tick();
    idle();
    set_req(32'h2000_6000, 2'd2);
    mgr_rsp[1].gnt = 1'b1;
    tick();
    idle();
    mgr_rsp[1].rvalid = 1'b1;
    tick();
    idle();
    tick();

`ifdef USER_DEMUX_ERR_LOG_EN
    set_req(32'h3000_0000, 2'd0);
    tick();
    set_req(32'h4000_0000, 2'd1);
    tick();
    idle();
    tick();
    chk("log_first", err_addr, 32'h3000_0000);
    set_req(32'h5000_0000, 2'd2);
    err_clear = 1'b1;
    tick();
    idle();
    tick();
    chk("log_clear_capture", err_addr, 32'h5000_0000);
    chk("log_clear_valid", 32'(err_valid), 32'd1);
`endif

    // Random traffic; an ungranted request is held stable
    for (int n = 0; n < 400; n++) begin
      if (!(sbr_req.req && !m_hs)) begin
        sbr_req.req     = ($urandom_range(0, 3) != 0);
        sbr_req.a.addr  = ($urandom_range(0, 9) == 0) ? $urandom : addrs[$urandom_range(0, 9)];
        sbr_req.a.aid   = 2'($urandom);
        sbr_req.a.we    = 1'($urandom);
        sbr_req.a.be    = 4'($urandom);
        sbr_req.a.wdata = $urandom;
      end
      for (int i = 0; i < 2; i++) begin
        mgr_rsp[i].gnt     = ($urandom_range(0, 3) != 0);
        mgr_rsp[i].rvalid  = 1'($urandom);
        mgr_rsp[i].r.rdata = $urandom;
        mgr_rsp[i].r.rid   = 2'($urandom);
        mgr_rsp[i].r.err   = ($urandom_range(0, 7) == 0);
      end
`ifdef USER_DEMUX_ERR_LOG_EN
      err_clear = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
